procedural_pipe: RTL and testbench
==================================

PROCEDURAL_PIPE -- requirements
Module: procedural_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the datapath width in bits (legal range 4..64).
REQ-002 The module SHALL have parameter MULT, default 10, an unsigned constant multiplier applied to (in1 + in2).
REQ-003 The module SHALL have parameter SHR, default 2, the logical right-shift amount of in1 on the sel=1 path.
REQ-004 The module SHALL have parameter SHL, default 3, the left-shift amount of in2 on the sel=0 path.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The module SHALL have ports in1 and in2, input, WIDTH bits each: unsigned operands.
REQ-008 The module SHALL have port sel, input, 1 bit: path select (1 = XOR/AND path, 0 = OR/ADD path).
REQ-009 The module SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): upstream handshake.
REQ-010 The module SHALL have ports out1 and out2, output, WIDTH bits each: results.
REQ-011 The module SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): downstream handshake.
REQ-012 The module SHALL have port clr, input, 1 bit: synchronous clear of the running sum.
REQ-013 The module SHALL have port out_sum, output, WIDTH bits: running modular sum of out2 over delivered results.

Function
REQ-014 All arithmetic SHALL be unsigned and truncated modulo 2^WIDTH at every stage; no saturation, no flags.
REQ-015 Stage 1 SHALL register t1 = ((in1 + in2) * MULT) mod 2^WIDTH, together with in1, in2 and sel.
REQ-016 Stage 2 SHALL register t2 = t1 ^ (in1 >> SHR) when sel=1, else t2 = t1 | (in2 << SHL); the right shift SHALL be logical (zero-fill).
REQ-017 Stage 3 SHALL register out1 = t2 & in2 when sel=1, else out1 = t2 + in1; it SHALL register out2 = t1 - t2 in both cases.
REQ-018 A transfer SHALL occur on the input when in_valid && in_ready, and on the output when out_valid && out_ready, both sampled at the rising edge of clk.
REQ-019 Each stage SHALL advance when it is empty or the stage downstream of it advances; in_ready SHALL equal (stage 1 empty || stage 1 advancing), combinationally.
REQ-020 Latency from input transfer to out_valid SHALL be exactly 3 cycles when out_ready is held high; sustained throughput SHALL be 1 result per cycle.
REQ-021 While out_valid=1 and out_ready=0, out1 and out2 SHALL hold stable and no accepted data SHALL be lost or duplicated; ordering SHALL be strictly FIFO.
REQ-022 On each output transfer, out_sum SHALL become (out_sum + out2) mod 2^WIDTH.
REQ-023 When clr=1 with no output transfer, out_sum SHALL become 0; when clr=1 coincides with an output transfer, out_sum SHALL become that transfer's out2.
REQ-024 Data registers SHALL NOT need reset; only the stage valid bits and out_sum need reset.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately clear all stage valid bits and out_sum, dropping any in-flight data.
REQ-026 During reset, out_valid SHALL be 0, in_ready SHALL be 0, and out_sum SHALL be 0; out1 and out2 are don't-care while out_valid=0.
REQ-027 in_ready SHALL become 1 in the first cycle after rst_n deasserts.

Structure
REQ-028 A shared package procedural_pipe_pkg SHALL hold default parameter constants (WIDTH, MULT, SHR, SHL); no typedefs are required.
REQ-029 The design SHALL use one generic sub-module, pipe_stage_ctl, instantiated three times, for the valid/advance logic of each stage; the datapath stays in the top module.

Verification
REQ-030 With WIDTH=16 and in1=3, in2=4, sel=1, the bench SHALL see out1=4, out2=0 exactly 3 cycles after acceptance.
REQ-031 With in1=3, in2=4, sel=0, the bench SHALL see t2=102, out1=105, out2=65504 (underflow wraps).
REQ-032 With in1=7000, in2=0, sel=1, the bench SHALL see t1=4464 (multiply wrap), out1=0, out2=63946.
REQ-033 With 8 back-to-back inputs and out_ready toggling 1,0,0,1,... the bench SHALL see all 8 results in order, none lost or duplicated, and outputs stable while stalled.
REQ-034 With out_sum=100 and clr=1 on the same cycle as an output transfer with out2=5, the bench SHALL see out_sum=5 next cycle; with clr=1 alone, out_sum=0.
REQ-035 With rst_n pulsed low while 2 results are in flight, the bench SHALL see out_valid=0 and out_sum=0 immediately, and in_ready=1 the cycle after release.

Source files
------------

// File: rtl/procedural_pipe_pkg.sv
// Shared default constants for the procedural_pipe datapath.
package procedural_pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_MULT  = 10;
  localparam int unsigned DEFAULT_SHR   = 2;
  localparam int unsigned DEFAULT_SHL   = 3;

endpackage : procedural_pipe_pkg

// File: rtl/pipe_stage_ctl.sv
// Valid-bit and advance control for one elastic pipeline stage.
// A stage advances when it is empty or when the stage downstream of it advances.
module pipe_stage_ctl (
  input  logic clk,
  input  logic rst_n,
  input  logic i_up_valid,
  input  logic i_down_advance,
  output logic o_valid,
  output logic o_advance
);

  logic r_valid;

  assign o_advance = !r_valid || i_down_advance;
  assign o_valid   = r_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (o_advance) begin
      r_valid <= i_up_valid;
    end
  end

endmodule : pipe_stage_ctl

// File: rtl/procedural_pipe.sv
// Three-stage valid/ready arithmetic pipeline with a running modular sum of out2.
// Control lives in three pipe_stage_ctl instances; the datapath is below.
module procedural_pipe
  import procedural_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned MULT  = DEFAULT_MULT,
  parameter int unsigned SHR   = DEFAULT_SHR,
  parameter int unsigned SHL   = DEFAULT_SHL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr,
  output logic [WIDTH-1:0] out_sum
);

  logic w_v1, w_v2, w_v3;
  logic w_adv1, w_adv2, w_adv3;
  logic w_in_xfer, w_out_xfer;
  logic r_run;

  // Holds in_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  assign in_ready   = r_run && w_adv1;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = w_v3 && out_ready;

  pipe_stage_ctl u_ctl_s1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_up_valid     (w_in_xfer),
    .i_down_advance (w_adv2),
    .o_valid        (w_v1),
    .o_advance      (w_adv1)
  );

  pipe_stage_ctl u_ctl_s2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_up_valid     (w_v1),
    .i_down_advance (w_adv3),
    .o_valid        (w_v2),
    .o_advance      (w_adv2)
  );

  pipe_stage_ctl u_ctl_s3 (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_up_valid     (w_v2),
    .i_down_advance (out_ready),
    .o_valid        (w_v3),
    .o_advance      (w_adv3)
  );

  // Stage 1: scaled sum, plus operands carried forward.
  logic [WIDTH-1:0] w_sum, w_t1;
  logic [WIDTH-1:0] r_t1, r_a1, r_b1;
  logic             r_s1;

  assign w_sum = in1 + in2;
  assign w_t1  = w_sum * WIDTH'(MULT);

  // NOTE: data registers carry no reset; the stage valid bits alone decide
  // whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (w_adv1) begin
      r_t1 <= w_t1;
      r_a1 <= in1;
      r_b1 <= in2;
      r_s1 <= sel;
    end
  end

  // Stage 2: logical right shift of in1 or left shift of in2 merged into t1.
  logic [WIDTH-1:0] w_t2;
  logic [WIDTH-1:0] r_t2, r_t1_s2, r_a2, r_b2;
  logic             r_s2;

  assign w_t2 = r_s1 ? (r_t1 ^ (r_a1 >> SHR)) : (r_t1 | (r_b1 << SHL));

  always_ff @(posedge clk) begin
    if (w_adv2) begin
      r_t2    <= w_t2;
      r_t1_s2 <= r_t1;
      r_a2    <= r_a1;
      r_b2    <= r_b1;
      r_s2    <= r_s1;
    end
  end

  // Stage 3: output registers, held while the consumer stalls.
  logic [WIDTH-1:0] r_out1, r_out2;

  always_ff @(posedge clk) begin
    if (w_adv3) begin
      r_out1 <= r_s2 ? (r_t2 & r_b2) : (r_t2 + r_a2);
      r_out2 <= r_t1_s2 - r_t2;
    end
  end

  // A clear coinciding with a delivery restarts the sum from that delivery.
  logic [WIDTH-1:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (clr) begin
      r_sum <= w_out_xfer ? r_out2 : '0;
    end else if (w_out_xfer) begin
      r_sum <= r_sum + r_out2;
    end
  end

  assign out1      = r_out1;
  assign out2      = r_out2;
  assign out_valid = w_v3;
  assign out_sum   = r_sum;

endmodule : procedural_pipe

// File: tb/tb_procedural_pipe.sv
// Directed bench for procedural_pipe: latency, arithmetic wrap, back-pressure,
// running-sum clear and asynchronous reset.
module tb_procedural_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in1, in2;
  logic        sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out1, out2;
  logic        out_valid;
  logic        out_ready;
  logic        clr;
  logic [15:0] out_sum;

  int n_checks = 0;
  int n_errors = 0;

  procedural_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1       (in1),
    .in2       (in2),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out1      (out1),
    .out2      (out2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr       (clr),
    .out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic at WIDTH=16, MULT=10, SHR=2, SHL=3; returns {out1, out2}.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] t1, t2, o1, o2;
    t1 = (a + b) * 16'd10;
    t2 = s ? (t1 ^ (a >> 2)) : (t1 | (b << 3));
    o1 = s ? (t2 & b) : (t2 + a);
    o2 = t1 - t2;
    return {o1, o2};
  endfunction

  logic [15:0] va[8];
  logic [15:0] vb[8];
  logic        vs[8];

  initial begin
    int          k;
    int          n_out;
    int          cyc;
    logic        accepted;
    logic        stall_now;
    logic [31:0] held;
    logic [31:0] expv;
    logic [15:0] exp_sum;

    rst_n = 1'b0; in1 = '0; in2 = '0; sel = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_sum", out_sum, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("release_in_ready_low", in_ready, 0);
    step();
    check("release_in_ready", in_ready, 1);

    // 3+4 on the XOR/AND path: three edges from acceptance to out_valid.
    in1 = 16'd3; in2 = 16'd4; sel = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_t1", dut.r_t1, 70);
    check("lat_valid_c1", out_valid, 0);
    step();
    check("lat_valid_c2", out_valid, 0);
    step();
    check("lat_valid_c3", out_valid, 1);
    check("xor_out1", out1, 4);
    check("xor_out2", out2, 0);

    // Same operands on the OR/ADD path: out2 underflows.
    in1 = 16'd3; in2 = 16'd4; sel = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("or_t1", dut.r_t1, 70);
    step();
    check("or_t2", dut.r_t2, 102);
    step();
    check("or_valid", out_valid, 1);
    check("or_out1", out1, 105);
    check("or_out2", out2, 65504);

    // Multiply wrap: 70000 mod 65536.
    in1 = 16'd7000; in2 = 16'd0; sel = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("wrap_t1", dut.r_t1, 4464);
    check("sum_after_two", out_sum, 65504);
    step();
    check("wrap_t2", dut.r_t2, 6054);
    step();
    check("wrap_out1", out1, 0);
    check("wrap_out2", out2, 63946);
    step();
    check("sum_wrap", out_sum, 63914);
    check("drained_valid", out_valid, 0);

    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_alone", out_sum, 0);

    // Eight back-to-back inputs against out_ready pattern 1,0,0 repeating.
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'(i * 1234 + 17);
      vb[i] = 16'(i * 777 + 5);
      vs[i] = i[0];
    end
    k = 0; n_out = 0; cyc = 0; exp_sum = '0;
    while (n_out < 8 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      if (k < 8) begin
        in_valid = 1'b1; in1 = va[k]; in2 = vb[k]; sel = vs[k];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        expv = model(va[n_out], vb[n_out], vs[n_out]);
        check($sformatf("stream_out1_%0d", n_out), out1, expv[31:16]);
        check($sformatf("stream_out2_%0d", n_out), out2, expv[15:0]);
        exp_sum = exp_sum + expv[15:0];
        n_out++;
      end
      accepted  = in_valid && in_ready;
      stall_now = out_valid && !out_ready;
      held      = {out1, out2};
      step();
      if (accepted) k++;
      if (stall_now) check($sformatf("stall_hold_c%0d", cyc), {out_valid, out1, out2}, {1'b1, held});
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_count", n_out, 8);
    check("stream_sum", out_sum, exp_sum);
    check("stream_drained", out_valid, 0);

    // clr together with a delivery: sum restarts from that delivery's out2.
    clr = 1'b1;
    step();
    clr = 1'b0;
    in1 = 16'd400; in2 = 16'd58; sel = 1'b1; in_valid = 1'b1;
    step();
    in1 = 16'd28; in2 = 16'd3; sel = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("clr_b_out2", out2, 100);
    check("clr_b_out1", out1, 0);
    step();
    check("clr_sum_100", out_sum, 100);
    check("clr_a_out2", out2, 5);
    check("clr_a_out1", out1, 1);
    clr = 1'b1;
    step();
    check("clr_with_xfer", out_sum, 5);
    check("clr_a_gone", out_valid, 0);
    step();
    clr = 1'b0;
    check("clr_no_xfer", out_sum, 0);

    // Reset with two results in flight.
    in1 = 16'd28; in2 = 16'd3; sel = 1'b1; in_valid = 1'b1;
    step();
    in1 = 16'd400; in2 = 16'd58;
    step();
    in1 = 16'd3; in2 = 16'd4; sel = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    check("pre_reset_sum", out_sum, 5);
    check("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_sum", out_sum, 0);
    check("async_in_ready", in_ready, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_dropped", out_valid, 0);
    repeat (3) step();
    check("post_reset_still_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_procedural_pipe
